// File: rtl/traffic_signal_monitor.sv
// Safety monitor between the traffic light controller and the physical lamps.
// Forwards lamp requests one cycle late; on the first violation it latches a code and flashes red.
module traffic_signal_monitor #(
    parameter int unsigned MIN_GREEN  = 3,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NS_green,
    input  logic             NS_yellow,
    input  logic             NS_red,
    input  logic             EW_green,
    input  logic             EW_yellow,
    input  logic             EW_red,
    output logic             NS_green_out,
    output logic             NS_yellow_out,
    output logic             NS_red_out,
    output logic             EW_green_out,
    output logic             EW_yellow_out,
    output logic             EW_red_out,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] phase_count
);

    typedef enum logic [1:0] {StInit, StMonitor, StFault} state_e;
    typedef enum logic [1:0] {LampNone, LampGreen, LampYellow, LampRed} lamp_e;

    localparam int unsigned FlashW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FlashW-1:0] FlashLast = FlashW'(FLASH_HALF - 1);
    localparam logic [7:0] DurMax    = 8'hFF;
    localparam logic [7:0] MinGreen  = 8'(MIN_GREEN);
    localparam logic [7:0] MinYellow = 8'(MIN_YELLOW);

    function automatic lamp_e encode_lamp(input logic g, input logic y, input logic r);
        if (g) begin
            return LampGreen;
        end else if (y) begin
            return LampYellow;
        end else if (r) begin
            return LampRed;
        end
        return LampNone;
    endfunction

    function automatic logic legal_step(input lamp_e from, input lamp_e to);
        return ((from == LampGreen)  && (to == LampYellow)) ||
               ((from == LampYellow) && (to == LampRed))    ||
               ((from == LampRed)    && (to == LampGreen));
    endfunction

    state_e            state_q, state_d;
    lamp_e             ns_prev_q, ns_prev_d, ew_prev_q, ew_prev_d;
    logic [7:0]        ns_dur_q, ns_dur_d, ew_dur_q, ew_dur_d;
    logic              ns_exempt_q, ns_exempt_d, ew_exempt_q, ew_exempt_d;
    logic              fault_q, fault_d;
    logic [2:0]        code_q, code_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic              red_on_q, red_on_d;
    logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
    logic [2:0]        ns_out_q, ns_out_d, ew_out_q, ew_out_d;

    lamp_e      ns_lamp, ew_lamp;
    logic       ns_one, ew_one, ns_chg, ew_chg;
    logic       viol1, viol2, viol3, viol4, viol5;
    logic [2:0] viol_code;
    logic       violation;

    // Exactly-one-hot: odd parity but not all three lit.
    assign ns_one  = (NS_green ^ NS_yellow ^ NS_red) & ~(NS_green & NS_yellow & NS_red);
    assign ew_one  = (EW_green ^ EW_yellow ^ EW_red) & ~(EW_green & EW_yellow & EW_red);
    assign ns_lamp = encode_lamp(NS_green, NS_yellow, NS_red);
    assign ew_lamp = encode_lamp(EW_green, EW_yellow, EW_red);
    assign ns_chg  = (ns_lamp != ns_prev_q);
    assign ew_chg  = (ew_lamp != ew_prev_q);

    assign viol1 = ~ns_one | ~ew_one;
    assign viol2 = ~NS_red & ~EW_red;
    assign viol3 = (ns_chg && !legal_step(ns_prev_q, ns_lamp)) ||
                   (ew_chg && !legal_step(ew_prev_q, ew_lamp));
    assign viol4 = (ns_chg && (ns_prev_q == LampGreen) && !ns_exempt_q && (ns_dur_q < MinGreen)) ||
                   (ew_chg && (ew_prev_q == LampGreen) && !ew_exempt_q && (ew_dur_q < MinGreen));
    assign viol5 = (ns_chg && (ns_prev_q == LampYellow) && !ns_exempt_q &&
                    (ns_dur_q < MinYellow)) ||
                   (ew_chg && (ew_prev_q == LampYellow) && !ew_exempt_q &&
                    (ew_dur_q < MinYellow));

    // Lowest-numbered violation wins; only checks 1 and 2 apply on the first edge.
    always_comb begin
        viol_code = 3'd0;
        if (state_q == StInit) begin
            if (viol1) begin
                viol_code = 3'd1;
            end else if (viol2) begin
                viol_code = 3'd2;
            end
        end else if (state_q == StMonitor) begin
            if (viol1) begin
                viol_code = 3'd1;
            end else if (viol2) begin
                viol_code = 3'd2;
            end else if (viol3) begin
                viol_code = 3'd3;
            end else if (viol4) begin
                viol_code = 3'd4;
            end else if (viol5) begin
                viol_code = 3'd5;
            end
        end
    end

    assign violation = (viol_code != 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:    state_d = violation ? StFault : StMonitor;
            StMonitor: state_d = violation ? StFault : StMonitor;
            StFault:   state_d = StFault;
            default:   state_d = StFault;
        endcase
    end

    always_comb begin
        ns_prev_d   = ns_prev_q;
        ew_prev_d   = ew_prev_q;
        ns_dur_d    = ns_dur_q;
        ew_dur_d    = ew_dur_q;
        ns_exempt_d = ns_exempt_q;
        ew_exempt_d = ew_exempt_q;
        fault_d     = fault_q;
        code_d      = code_q;
        phase_d     = phase_q;
        red_on_d    = red_on_q;
        flash_cnt_d = flash_cnt_q;
        ns_out_d    = ns_out_q;
        ew_out_d    = ew_out_q;

        if (state_q == StFault) begin
            if (flash_cnt_q == FlashLast) begin
                flash_cnt_d = '0;
                red_on_d    = ~red_on_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FlashW'(1);
            end
            ns_out_d = {2'b00, red_on_d};
            ew_out_d = {2'b00, red_on_d};
        end else if (violation) begin
            fault_d     = 1'b1;
            code_d      = viol_code;
            red_on_d    = 1'b1;
            flash_cnt_d = '0;
            ns_out_d    = 3'b001;
            ew_out_d    = 3'b001;
        end else begin
            ns_out_d = {NS_green, NS_yellow, NS_red};
            ew_out_d = {EW_green, EW_yellow, EW_red};
            if (state_q == StInit) begin
                ns_prev_d   = ns_lamp;
                ew_prev_d   = ew_lamp;
                ns_dur_d    = 8'd1;
                ew_dur_d    = 8'd1;
                ns_exempt_d = 1'b1;
                ew_exempt_d = 1'b1;
            end else begin
                if (ns_chg) begin
                    ns_prev_d   = ns_lamp;
                    ns_dur_d    = 8'd1;
                    ns_exempt_d = 1'b0;
                end else if (ns_dur_q != DurMax) begin
                    ns_dur_d = ns_dur_q + 8'd1;
                end
                if (ew_chg) begin
                    ew_prev_d   = ew_lamp;
                    ew_dur_d    = 8'd1;
                    ew_exempt_d = 1'b0;
                end else if (ew_dur_q != DurMax) begin
                    ew_dur_d = ew_dur_q + 8'd1;
                end
                if ((ns_prev_q == LampRed) && (ns_lamp == LampGreen)) begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ns_prev_q   <= LampNone;
            ew_prev_q   <= LampNone;
            ns_dur_q    <= 8'd0;
            ew_dur_q    <= 8'd0;
            ns_exempt_q <= 1'b0;
            ew_exempt_q <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
            phase_q     <= '0;
            red_on_q    <= 1'b1;
            flash_cnt_q <= '0;
            ns_out_q    <= 3'b001;
            ew_out_q    <= 3'b001;
        end else begin
            ns_prev_q   <= ns_prev_d;
            ew_prev_q   <= ew_prev_d;
            ns_dur_q    <= ns_dur_d;
            ew_dur_q    <= ew_dur_d;
            ns_exempt_q <= ns_exempt_d;
            ew_exempt_q <= ew_exempt_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            phase_q     <= phase_d;
            red_on_q    <= red_on_d;
            flash_cnt_q <= flash_cnt_d;
            ns_out_q    <= ns_out_d;
            ew_out_q    <= ew_out_d;
        end
    end

    assign {NS_green_out, NS_yellow_out, NS_red_out} = ns_out_q;
    assign {EW_green_out, EW_yellow_out, EW_red_out} = ew_out_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign phase_count = phase_q;

endmodule
